clock_freq_meter: RTL and testbench

Measures the frequency of an externally generated signal, such as the board's `clk_out` looped back to a pin, by counting its rising edges over a fixed gate window of local clock cycles. It is the receiving end of the clock-output path in the simple FPGA CVS design: the design drives a clock out, and this block samples it back and reports edges-per-window. It is a single-clock, fully synchronous block. The measured input is treated as asynchronous and is brought in through a synchroniser.

---
 rtl/clock_meas_pkg.sv | 14 +
 rtl/sync_edge_detect.sv | 36 +++
 rtl/clock_freq_meter.sv | 135 +++++++++++++
 tb/tb_clock_freq_meter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_meas_pkg.sv
// Shared types and default parameters for the clock frequency meter.
package clock_meas_pkg;

  // Measurement controller states.
  typedef enum logic {
    IDLE   = 1'b0,
    WINDOW = 1'b1
  } meter_state_t;

  localparam int unsigned DEFAULT_GATE_CYCLES = 1000;
  localparam int unsigned DEFAULT_COUNT_WIDTH = 16;
  localparam int unsigned DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Brings an asynchronous level into the clock domain and flags its rising edges.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   d            : asynchronous input level
//   level        : synchronised copy of d
//   rise         : one-cycle pulse on each synchronised 0->1 transition
module sync_edge_detect
  import clock_meas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchroniser chain followed by one history flop for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;

endmodule

// File: rtl/clock_freq_meter.sv
// Counts rising edges of an asynchronous input over back-to-back gate windows
// of GATE_CYCLES local clock cycles and reports the count per window.
// Ports:
//   clock, reset  : single clock and synchronous active-high reset
//   meas_in       : asynchronous signal being measured
//   enable        : level; windows run back-to-back while high
//   busy          : high while a window is in progress
//   result        : saturated edge count of the last completed window
//   result_valid  : one-cycle pulse when result updates
//   overflow      : the last completed window saturated its count
module clock_freq_meter
  import clock_meas_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int unsigned COUNT_WIDTH = DEFAULT_COUNT_WIDTH,
  parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   meas_in,
  input  logic                   enable,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   result_valid,
  output logic                   overflow
);

  localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0]      GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  meter_state_t           state_q;
  meter_state_t           state_d;
  logic [GATE_W-1:0]      gate_cnt_q;
  logic [COUNT_WIDTH-1:0] edge_cnt_q;
  logic                   ovf_q;

  logic                   rise;
  logic                   sync_level_unused;

  logic                   last_cycle_c;
  logic [COUNT_WIDTH-1:0] edge_cnt_next_c;
  logic                   ovf_next_c;

  // Input synchroniser and rising-edge detector.
  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock (clock),
    .reset (reset),
    .d     (meas_in),
    .level (sync_level_unused),
    .rise  (rise)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the last window cycle always completes, even if enable drops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WINDOW;
        end
      end
      WINDOW: begin
        if (last_cycle_c) begin
          state_d = enable ? WINDOW : IDLE;
        end else if (!enable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window-end detection and saturating edge-count update for this cycle.
  always_comb begin
    last_cycle_c    = 1'b0;
    edge_cnt_next_c = edge_cnt_q;
    ovf_next_c      = ovf_q;
    if (state_q == WINDOW) begin
      last_cycle_c = (gate_cnt_q == GATE_LAST);
      if (rise) begin
        // Compare before adding so the count never wraps.
        if (edge_cnt_q == COUNT_MAX) begin
          ovf_next_c = 1'b1;
        end else begin
          edge_cnt_next_c = edge_cnt_q + COUNT_WIDTH'(1);
        end
      end
    end
  end

  // Counters and registered outputs; counters clear whenever a window is not continuing.
  always_ff @(posedge clock) begin
    if (reset) begin
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      busy         <= (state_d == WINDOW);

      if ((state_q == WINDOW) && !last_cycle_c) begin
        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
        edge_cnt_q <= edge_cnt_next_c;
        ovf_q      <= ovf_next_c;
      end else begin
        gate_cnt_q <= '0;
        edge_cnt_q <= '0;
        ovf_q      <= 1'b0;
      end

      if (last_cycle_c) begin
        result       <= edge_cnt_next_c;
        overflow     <= ovf_next_c;
        result_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_freq_meter.sv
`timescale 1ps/100fs
module tb_clock_freq_meter;

  localparam int unsigned GATE = 100;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        meas_in = 1'b0;

  logic        busy16, rv16, ovf16;
  logic [15:0] result16;
  logic        busy4, rv4, ovf4;
  logic [3:0]  result4;

  clock_freq_meter #(
    .GATE_CYCLES (GATE),
    .COUNT_WIDTH (16),
    .SYNC_STAGES (2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .meas_in      (meas_in),
    .enable       (enable),
    .busy         (busy16),
    .result       (result16),
    .result_valid (rv16),
    .overflow     (ovf16)
  );

  clock_freq_meter #(
    .GATE_CYCLES (GATE),
    .COUNT_WIDTH (4),
    .SYNC_STAGES (2)
  ) dut_sat (
    .clock        (clock),
    .reset        (reset),
    .meas_in      (meas_in),
    .enable       (enable),
    .busy         (busy4),
    .result       (result4),
    .result_valid (rv4),
    .overflow     (ovf4)
  );

  always #1 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Waveform generator: period 0 means hold meas_in at 'hold'.
  int   per = 0;
  logic hold = 1'b0;
  int   gcnt = 0;
  int   last_per = 0;
  always @(negedge clock) begin
    if (per != last_per) begin
      gcnt = 0;
      last_per = per;
    end
    if (per == 0) begin
      meas_in = hold;
    end else begin
      meas_in = (gcnt < per / 2);
      gcnt = (gcnt + 1 >= per) ? 0 : gcnt + 1;
    end
  end

  typedef struct {
    logic [15:0] r16;
    logic        o16;
    logic [3:0]  r4;
    logic        o4;
  } exp_t;

  typedef struct {
    int          per;
    logic        hold;
    int          nwin;
    logic [15:0] r16;
    logic [3:0]  r4;
    logic        o4;
  } vec_t;

  exp_t sb_q[$];
  int   pulse_cyc[$];
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [15:0] r16, input logic [3:0] r4, input logic o4);
    exp_t e;
    e.r16 = r16;
    e.o16 = 1'b0;
    e.r4  = r4;
    e.o4  = o4;
    sb_q.push_back(e);
  endtask

  // Scoreboard side: compare each result_valid pulse against the queued expectation.
  task automatic sample();
    exp_t e;
    if (rv16 || rv4) begin
      chk("valid_align", 32'(rv4), 32'(rv16));
      pulse_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got pulse with result %0d expected none (cycle %0d)", result16, cyc);
      end else begin
        e = sb_q.pop_front();
        chk("result16", 32'(result16), 32'(e.r16));
        chk("overflow16", 32'(ovf16), 32'(e.o16));
        chk("result4", 32'(result4), 32'(e.r4));
        chk("overflow4", 32'(ovf4), 32'(e.o4));
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    sample();
    #0.2;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick();
  endtask

  task automatic drain(input int budget);
    int b;
    b = budget;
    while (sb_q.size() != 0 && b > 0) begin
      tick();
      b--;
    end
    if (sb_q.size() != 0) begin
      chk("timeout_pending", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic check_pulses(input int c0, input int n);
    chk("pulse_count", 32'(pulse_cyc.size()), 32'(n));
    if (pulse_cyc.size() > 0) chk("start_latency", 32'(pulse_cyc[0] - c0), 32'(GATE + 1));
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk("pulse_interval", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(GATE));
  endtask

  task automatic run_vec(input vec_t v);
    int c0;
    enable = 1'b0;
    per    = v.per;
    hold   = v.hold;
    repeat (2 * v.per + 10) tick();
    pulse_cyc.delete();
    for (int i = 0; i < v.nwin; i++) push_exp(v.r16, v.r4, v.o4);
    enable = 1'b1;
    c0 = cyc;
    drain(v.nwin * GATE + 50);
    enable = 1'b0;
    check_pulses(c0, v.nwin);
    repeat (5) tick();
    chk("busy_after_stop", 32'(busy16), 32'd0);
  endtask

  initial begin
    int c0;
    int c1;
    int hold_at[8];
    logic hold_val[8];

    vecs[0] = '{10, 1'b0, 3, 16'd10, 4'd10, 1'b0};
    vecs[1] = '{0,  1'b0, 1, 16'd0,  4'd0,  1'b0};
    vecs[2] = '{0,  1'b1, 1, 16'd0,  4'd0,  1'b0};
    vecs[3] = '{4,  1'b0, 3, 16'd25, 4'd15, 1'b1};
    vecs[4] = '{20, 1'b0, 2, 16'd5,  4'd5,  1'b0};
    vecs[5] = '{5,  1'b0, 2, 16'd20, 4'd15, 1'b1};
    vecs[6] = '{50, 1'b0, 1, 16'd2,  4'd2,  1'b0};

    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy16), 32'd0);
    chk("rst_result", 32'(result16), 32'd0);
    chk("rst_valid", 32'(rv16), 32'd0);
    chk("rst_overflow", 32'(ovf16), 32'd0);
    chk("rst_result4", 32'(result4), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Abort at window cycle 50: no pulse, result kept, then clean restart.
    per = 10;
    repeat (30) tick();
    pulse_cyc.delete();
    enable = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 51);
    chk("abort_busy_before", 32'(busy16), 32'd1);
    enable = 1'b0;
    tick();
    chk("abort_busy_after", 32'(busy16), 32'd0);
    chk("abort_busy4_after", 32'(busy4), 32'd0);
    chk("abort_result_kept", 32'(result16), 32'd2);
    chk("abort_result4_kept", 32'(result4), 32'd2);
    chk("abort_ovf_kept", 32'(ovf16), 32'd0);
    repeat (150) tick();
    chk("abort_no_pulse", 32'(pulse_cyc.size()), 32'd0);
    push_exp(16'd10, 4'd10, 1'b0);
    enable = 1'b1;
    c0 = cyc;
    drain(GATE + 50);
    enable = 1'b0;
    check_pulses(c0, 1);
    repeat (5) tick();

    // Reset at window cycle 30 with enable held; a fresh window follows.
    pulse_cyc.delete();
    enable = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 31);
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(busy16), 32'd0);
    chk("midrst_result", 32'(result16), 32'd0);
    chk("midrst_valid", 32'(rv16), 32'd0);
    chk("midrst_overflow", 32'(ovf16), 32'd0);
    chk("midrst_busy4", 32'(busy4), 32'd0);
    chk("midrst_result4", 32'(result4), 32'd0);
    reset = 1'b0;
    push_exp(16'd10, 4'd10, 1'b0);
    c1 = cyc;
    drain(GATE + 50);
    enable = 1'b0;
    check_pulses(c1, 1);
    repeat (5) tick();

    // Edge whose rise lands on the last window cycle: counted there, not in the next window.
    per  = 0;
    hold = 1'b0;
    repeat (10) tick();
    hold_at  = '{9, 12, 29, 32, 49, 52, 97, 0};
    hold_val = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    pulse_cyc.delete();
    push_exp(16'd4, 4'd4, 1'b0);
    push_exp(16'd0, 4'd0, 1'b0);
    enable = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      wait_cyc(c0 + hold_at[i]);
      hold = hold_val[i];
    end
    drain(2 * GATE + 50);
    enable = 1'b0;
    check_pulses(c0, 2);
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
